// File: rtl/fifo_defs_pkg.sv
// ---------------------------------------------------------------------------
// fifo_defs
// Shared definitions for the dual-clock FIFO pointer controllers (write and
// read side). Holds the default address width, helpers to derive pointer
// width and depth, and the binary/Gray conversion functions.
//
// The conversion functions work on a fixed 32-bit container. Zero-extending a
// narrower pointer does not change its converted value, because the leading
// zeros stay zero in both directions. Callers therefore cast in and out at
// their own pointer width.
// ---------------------------------------------------------------------------
package fifo_defs;

    localparam int ADDR_W_DEF = 2;
    localparam int CONV_W     = 32;

    // The pointer carries one extra wrap bit above the memory address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // The MSB is copied. Each lower bit is the XOR of its Gray bit with the
    // binary bit just above it.
    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a bus that is already safe to sample bit-by-bit,
// such as a Gray-coded pointer. There is deliberately no logic between the
// two flops. Both stages clear to 0 on a synchronous reset.
//
// Ports:
//   clk   in  1  destination-domain clock
//   srst  in  1  synchronous active-high reset
//   d     in  W  asynchronous input bus
//   q     out W  synchronised output (second stage)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         srst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side pointer controller for the dual-clock FIFO. It accepts writes,
// drives the memory write port, keeps the binary and registered Gray write
// pointers, and synchronises the read pointer into this domain. From these it
// derives full, almost_full, the fill level and a sticky overflow flag.
//
// Ports:
//   clk_en       in  1       write-domain clock (rising edge)
//   rst          in  1       synchronous active-high reset
//   wr_req       in  1       write request (may be held high)
//   wr_ack       out 1       write accepted this cycle (combinational)
//   mem_we       out 1       memory write enable (same as wr_ack)
//   mem_waddr    out ADDR_W  memory write address
//   rd_ptr_gray  in  PTR_W   read pointer, Gray coded, asynchronous
//   wr_ptr_gray  out PTR_W   registered Gray write pointer for the read side
//   full         out 1       registered; no write is accepted while high
//   almost_full  out 1       registered; level >= DEPTH-1
//   level        out PTR_W   registered conservative fill count, 0..DEPTH
//   overflow     out 1       sticky; a request was seen while full
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_defs::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int PTR_W = ptr_width(ADDR_W),
    localparam int DEPTH = fifo_depth(ADDR_W)
) (
    input  logic              clk_en,
    input  logic              rst,
    input  logic              wr_req,
    output logic              wr_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    input  logic [PTR_W-1:0]  rd_ptr_gray,
    output logic [PTR_W-1:0]  wr_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [PTR_W-1:0]  level,
    output logic              overflow
);

    // When the FIFO is full, the write Gray pointer equals the read Gray
    // pointer with its top two bits inverted. Using a shifted mask keeps this
    // legal even when ADDR_W is 1 and there are no bits below those two.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
    localparam logic [PTR_W-1:0] AF_LIMIT  = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] wbin_reg;
    logic [PTR_W-1:0] wbin_next;
    logic [PTR_W-1:0] wgray_reg;
    logic [PTR_W-1:0] wgray_next;
    logic [PTR_W-1:0] rq2;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] level_reg;
    logic [PTR_W-1:0] level_next;
    logic             full_reg;
    logic             full_next;
    logic             almost_full_reg;
    logic             overflow_reg;

    sync_2ff #(
        .W (PTR_W)
    ) u_rd_sync (
        .clk  (clk_en),
        .srst (rst),
        .d    (rd_ptr_gray),
        .q    (rq2)
    );

    assign wr_ack    = wr_req & ~full_reg & ~rst;
    assign mem_we    = wr_ack;
    assign mem_waddr = wbin_reg[ADDR_W-1:0];

    // The pointer wraps naturally at 2**PTR_W. The wrap bit tells full apart
    // from empty.
    assign wbin_next  = wbin_reg + PTR_W'(wr_ack);
    assign wgray_next = PTR_W'(bin2gray(CONV_W'(wbin_next)));
    assign rbin_s     = PTR_W'(gray2bin(CONV_W'(rq2)));

    // rq2 lags the real read pointer. That lag can only make the level and
    // full flags too high, never too low, so the flags err on the safe side.
    assign level_next = wbin_next - rbin_s;
    assign full_next  = (wgray_next == (rq2 ^ FULL_MASK));

    always_ff @(posedge clk_en) begin
        if (rst) begin
            wbin_reg        <= '0;
            wgray_reg       <= '0;
            level_reg       <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            wbin_reg        <= wbin_next;
            wgray_reg       <= wgray_next;
            level_reg       <= level_next;
            full_reg        <= full_next;
            almost_full_reg <= (level_next >= AF_LIMIT);
            overflow_reg    <= overflow_reg | (wr_req & full_reg);
        end
    end

    assign wr_ptr_gray = wgray_reg;
    assign full        = full_reg;
    assign almost_full = almost_full_reg;
    assign level       = level_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Directed testbench for fifo_wr_ctrl with ADDR_W=2, so DEPTH=4 and PTR_W=3.
// Inputs are driven 1 time unit after the rising edge. Combinational outputs
// are checked 1 unit after the inputs change. Registered outputs are checked
// 1 unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int ADDR_W = 2;
    localparam int PTR_W  = 3;

    logic              clk_en = 1'b0;
    logic              rst;
    logic              wr_req;
    logic              wr_ack;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [PTR_W-1:0]  rd_ptr_gray;
    logic [PTR_W-1:0]  rd_fixed;
    logic              track;
    logic [PTR_W-1:0]  wr_ptr_gray;
    logic              full;
    logic              almost_full;
    logic [PTR_W-1:0]  level;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Gray codes for binary values 0..7.
    logic [PTR_W-1:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b110, 3'b111, 3'b101, 3'b100};

    always #5 clk_en = ~clk_en;

    // In tracking mode the reader follows the writer's published pointer.
    assign rd_ptr_gray = track ? wr_ptr_gray : rd_fixed;

    fifo_wr_ctrl #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_en      (clk_en),
        .rst         (rst),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .rd_ptr_gray (rd_ptr_gray),
        .wr_ptr_gray (wr_ptr_gray),
        .full        (full),
        .almost_full (almost_full),
        .level       (level),
        .overflow    (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_en);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 0);
        check({tag, ".full"},        32'(full),        0);
        check({tag, ".almost_full"}, 32'(almost_full), 0);
        check({tag, ".level"},       32'(level),       0);
        check({tag, ".overflow"},    32'(overflow),    0);
        check({tag, ".mem_waddr"},   32'(mem_waddr),   0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_req   = 1'b1;
        rd_fixed = '0;
        track    = 1'b0;

        // ---- Reset held 2 cycles with a request pending ----
        #1;
        check("rst.wr_ack", 32'(wr_ack), 0);
        check("rst.mem_we", 32'(mem_we), 0);
        step();
        step();
        check("rst.wr_ack2", 32'(wr_ack), 0);
        check_all_zero("rst");
        wr_req = 1'b0;
        rst    = 1'b0;
        step();
        check("rst.overflow_after", 32'(overflow), 0);

        // ---- Fill: 5 requests, only 4 accepted ----
        wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("fill%0d.wr_ack", i), 32'(wr_ack), (i < 4) ? 1 : 0);
            check($sformatf("fill%0d.mem_we", i), 32'(mem_we), (i < 4) ? 1 : 0);
            if (i < 4) check($sformatf("fill%0d.mem_waddr", i), 32'(mem_waddr), i);
            @(posedge clk_en);
            #1;
            check($sformatf("fill%0d.wr_ptr_gray", i), 32'(wr_ptr_gray),
                  32'(gray_tab[(i < 4) ? i + 1 : 4]));
            check($sformatf("fill%0d.almost_full", i), 32'(almost_full), (i >= 2) ? 1 : 0);
            check($sformatf("fill%0d.full", i), 32'(full), (i >= 3) ? 1 : 0);
            check($sformatf("fill%0d.level", i), 32'(level), (i < 4) ? i + 1 : 4);
            check($sformatf("fill%0d.overflow", i), 32'(overflow), (i == 4) ? 1 : 0);
        end
        wr_req = 1'b0;

        // ---- Release: reader advances to 1, seen 3 edges later ----
        rd_fixed = 3'b001;
        step();
        check("rel.e1.full", 32'(full), 1);
        step();
        check("rel.e2.full", 32'(full), 1);
        step();
        check("rel.e3.full", 32'(full), 0);
        check("rel.e3.level", 32'(level), 3);
        check("rel.e3.almost_full", 32'(almost_full), 1);
        wr_req = 1'b1;
        #1;
        check("rel.wr_ack", 32'(wr_ack), 1);
        check("rel.mem_waddr", 32'(mem_waddr), 0);
        step();
        wr_req = 1'b0;
        check("rel.refull", 32'(full), 1);
        check("rel.level", 32'(level), 4);
        check("rel.wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray_tab[5]));

        // ---- Mid-operation reset while full and overflowed ----
        check("mid.pre_overflow", 32'(overflow), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("mid");
        rd_fixed = '0;
        wr_req   = 1'b1;
        #1;
        check("mid.wr_ack", 32'(wr_ack), 1);
        check("mid.mem_waddr", 32'(mem_waddr), 0);
        step();
        wr_req = 1'b0;
        check("mid.wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray_tab[1]));

        // ---- Wrap: reader tracks writer over 9 writes ----
        track = 1'b1;
        rst   = 1'b1;
        step();
        rst    = 1'b0;
        wr_req = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            check($sformatf("wrap%0d.wr_ack", k), 32'(wr_ack), 1);
            check($sformatf("wrap%0d.mem_waddr", k), 32'(mem_waddr), (k - 1) % 4);
            @(posedge clk_en);
            #1;
            check($sformatf("wrap%0d.wr_ptr_gray", k), 32'(wr_ptr_gray), 32'(gray_tab[k % 8]));
            check($sformatf("wrap%0d.full", k), 32'(full), 0);
            check($sformatf("wrap%0d.level", k), 32'(level), (k < 3) ? k : 3);
        end
        wr_req = 1'b0;
        track  = 1'b0;

        // ---- Simultaneous write and read-pointer advance ----
        rd_fixed = '0;
        rst      = 1'b1;
        step();
        rst    = 1'b0;
        wr_req = 1'b1;
        step();
        step();
        wr_req = 1'b0;
        check("sim.level_start", 32'(level), 2);
        rd_fixed = 3'b001;
        step();
        check("sim.eA.level", 32'(level), 2);
        step();
        check("sim.eB.level", 32'(level), 2);
        wr_req = 1'b1;
        #1;
        check("sim.wr_ack", 32'(wr_ack), 1);
        check("sim.mem_waddr", 32'(mem_waddr), 2);
        step();
        wr_req = 1'b0;
        check("sim.eC.level", 32'(level), 2);
        check("sim.eC.wr_ptr_gray", 32'(wr_ptr_gray), 32'(gray_tab[3]));
        step();
        check("sim.eD.level", 32'(level), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
